bank_loader: RTL and testbench
==============================

BANK_LOADER -- requirements
Module: bank_loader

Interface
REQ-001 Parameter DATA_W, default 12: coefficient width.
REQ-002 Parameter Q, default 3329: modulus; the block requires Q < 2^DATA_W.
REQ-003 Parameter N, default 256: polynomial length; multiple of 4; the bank depth is N/4.
REQ-004 Parameter ADDR_W, default 6: bank address width, equal to log2(N/4).
REQ-005 Port clk, input, 1: sole clock; all state updates on the rising edge.
REQ-006 Port rst, input, 1: asynchronous, active-high reset.
REQ-007 Port load_req, input, 1: single-cycle request to start loading a polynomial.
REQ-008 Port in_valid, input, 1: in_data is valid this cycle.
REQ-009 Port in_data, input, DATA_W: coefficient value, streamed in index order 0..N-1.
REQ-010 Port in_ready, output, 1: the block accepts in_data this cycle.
REQ-011 Port wr_en, output, 4: one-hot write enable, bit b for bank b.
REQ-012 Port wr_addr, output, ADDR_W: bank write address, shared by all banks.
REQ-013 Port wr_data, output, DATA_W: bank write data, shared by all banks.
REQ-014 Port start_ntt, output, 1: one-cycle pulse that launches the downstream NTT stage.
REQ-015 Port ntt_done, input, 1: level from the NTT stage; high when the transform is complete.
REQ-016 Port busy, output, 1: high whenever the state is not IDLE.
REQ-017 Port range_err, output, 1: sticky flag for an out-of-range coefficient.

Function
REQ-018 The block shall implement the states IDLE, LOAD, FLUSH, START and WAIT_NTT.
REQ-019 IDLE->LOAD on load_req=1; load_req in any other state shall be ignored.
REQ-020 Entering LOAD, the index counter idx (log2(N) bits) shall be 0 and range_err shall be cleared.
REQ-021 in_ready shall be 1 exactly when state==LOAD; it is combinational from state only.
REQ-022 A transfer occurs when in_valid=1 and in_ready=1; each transfer increments idx by 1.
REQ-023 Each accepted coefficient shall be reduced once: the result is in_data-Q if in_data>=Q, else in_data (DATA_W-bit arithmetic).
REQ-024 If an accepted in_data>=2Q, range_err shall be set and remain 1 until the next LOAD entry; the reduced value is still written.
REQ-025 Address mapping: bank = idx[1:0], wr_addr = idx[log2(N)-1:2].
REQ-026 A transfer at cycle k shall produce a registered write at cycle k+1: wr_en has bit bank set, together with wr_addr and the reduced wr_data.
REQ-027 wr_en shall be 0 in every cycle without a pending write.
REQ-028 In-LOAD gaps (in_valid=0) shall stall idx with no write; there is no timeout.
REQ-029 The transfer with idx==N-1 shall move the state LOAD->FLUSH; idx wraps to 0.
REQ-030 FLUSH lasts one cycle; it carries the final write (bank 3, address N/4-1).
REQ-031 FLUSH->START; in START, start_ntt=1 for exactly one cycle, then START->WAIT_NTT.
REQ-032 WAIT_NTT->IDLE on the first cycle ntt_done=1; while in WAIT_NTT, wr_en stays 0.
REQ-033 If ntt_done is already 1 on entering WAIT_NTT, the block shall return to IDLE the next cycle.

Reset
REQ-034 While rst=1, asynchronously: state=IDLE, idx=0, wr_en=0, wr_addr=0, wr_data=0, start_ntt=0, range_err=0, in_ready=0, busy=0.
REQ-035 A reset mid-LOAD shall abandon the partial load; no write and no start_ntt shall occur after reset release until a new load_req.
REQ-036 The first load_req is honoured on the first rising edge after rst deasserts.

Verification
REQ-037 Stream in_data=i for i=0..255 with in_valid held high -> 256 writes; i=5 goes to bank 1, addr 1, data 5; the final write (bank 3, addr 63, data 255) occurs in FLUSH; start_ntt pulses 2 cycles after the last transfer; range_err=0.
REQ-038 Stream values 3328, 3329, 3330, 6658 -> written as 3328, 0, 1 and 3329; range_err=1 only from the transfer of 6658 onward.
REQ-039 Drive in_valid with a 1-on/2-off pattern -> writes equal transfers, idx holds during gaps, and write order is unchanged.
REQ-040 Assert rst after 100 transfers, then issue a new load_req -> wr_en stays 0 during reset, and the new load writes bank 0, addr 0 first.
REQ-041 Assert load_req during WAIT_NTT -> ignored; raise ntt_done -> IDLE the next cycle and busy=0; a subsequent load_req is accepted.
REQ-042 Hold ntt_done=1 before START -> WAIT_NTT lasts 1 cycle; start_ntt is asserted exactly once.

Source files
------------

// File: rtl/bank_loader.sv
// ---------------------------------------------------------------------------
// bank_loader
//
// Accepts a polynomial of N coefficients streamed in index order, reduces
// each coefficient once modulo Q and writes it into four interleaved
// coefficient banks. Coefficient idx goes to bank idx[1:0] at address
// idx[log2(N)-1:2]. When the last coefficient has been written, the block
// pulses start_ntt once to launch the downstream NTT stage. It then waits for
// that stage to report completion before it accepts another load.
//
// Parameters
//   DATA_W  coefficient width
//   Q       modulus (must be below 2^DATA_W)
//   N       polynomial length (multiple of 4)
//   ADDR_W  bank address width, log2(N/4)
//
// Ports
//   clk        sole clock, rising edge
//   rst        asynchronous active-high reset
//   load_req   single-cycle request to start loading (honoured only in IDLE)
//   in_valid   in_data is valid this cycle
//   in_data    coefficient value, streamed in index order
//   in_ready   high exactly while loading
//   wr_en      one-hot bank write enable (bit b -> bank b)
//   wr_addr    bank write address, shared by all banks
//   wr_data    reduced coefficient, shared by all banks
//   start_ntt  one-cycle launch pulse for the NTT stage
//   ntt_done   level from the NTT stage, high when the transform is complete
//   busy       high whenever the block is not idle
//   range_err  sticky flag: some coefficient of this load was >= 2Q
// ---------------------------------------------------------------------------
module bank_loader #(
  parameter int DATA_W = 12,
  parameter int Q      = 3329,
  parameter int N      = 256,
  parameter int ADDR_W = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_req,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic [3:0]        wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data,
  output logic              start_ntt,
  input  logic              ntt_done,
  output logic              busy,
  output logic              range_err
);

  // The index counter covers the whole polynomial. Its two low bits select
  // the bank and the remaining bits form the bank address.
  localparam int IDX_W = ADDR_W + 2;

  localparam logic [IDX_W-1:0]  IDX_LAST = IDX_W'(N - 1);
  localparam logic [DATA_W-1:0] Q_W      = DATA_W'(Q);
  // 2Q can exceed DATA_W bits, so the range check uses one extra bit.
  localparam logic [DATA_W:0]   Q2_W     = (DATA_W + 1)'(2 * Q);

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_LOAD     = 3'd1;
  localparam logic [2:0] S_FLUSH    = 3'd2;
  localparam logic [2:0] S_START    = 3'd3;
  localparam logic [2:0] S_WAIT_NTT = 3'd4;

  logic [2:0]        state;
  logic [2:0]        state_next;
  logic [IDX_W-1:0]  idx;
  logic              transfer;
  logic              last_transfer;
  logic              load_start;
  logic              over_q;
  logic              over_2q;
  logic [DATA_W-1:0] reduced;

  // Handshake and status outputs depend on the state register alone. This
  // keeps in_ready free of any combinational path from the inputs, and every
  // one of them drops to 0 as soon as reset forces the state to IDLE.
  assign in_ready  = (state == S_LOAD);
  assign busy      = (state != S_IDLE);
  assign start_ntt = (state == S_START);

  assign transfer      = in_valid & in_ready;
  assign last_transfer = transfer && (idx == IDX_LAST);
  assign load_start    = (state == S_IDLE) && load_req;

  // A single conditional subtraction is the whole reduction. Inputs at or
  // above 2Q cannot be fully reduced this way. They are still written
  // (reduced once) and flagged through range_err.
  assign over_q  = (in_data >= Q_W);
  assign over_2q = ({1'b0, in_data} >= Q2_W);
  assign reduced = over_q ? (in_data - Q_W) : in_data;

  // Next-state logic.
  // - Loading ends on the transfer of the last index.
  // - FLUSH is the one cycle in which the final registered write appears.
  // - START issues the launch pulse.
  // - WAIT_NTT holds until the NTT stage reports done. If ntt_done is
  //   already high on entry, the block leaves after one cycle.
  // A load_req seen outside IDLE is ignored.
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:     if (load_req) state_next = S_LOAD;
      S_LOAD:     if (last_transfer) state_next = S_FLUSH;
      S_FLUSH:    state_next = S_START;
      S_START:    state_next = S_WAIT_NTT;
      S_WAIT_NTT: if (ntt_done) state_next = S_IDLE;
      default:    state_next = S_IDLE;
    endcase
  end

  // State register. Reset abandons any partial load immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Index counter.
  // - It restarts at 0 whenever a load begins.
  // - It advances only on an accepted transfer, so gaps in in_valid stall it.
  // - After the last index it wraps to 0 naturally.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx <= '0;
    end else if (load_start) begin
      idx <= '0;
    end else if (transfer) begin
      idx <= idx + IDX_W'(1);
    end
  end

  // Bank write port, registered one cycle behind the transfer.
  // - wr_en is rebuilt every cycle, so it is zero whenever no write is pending.
  // - Address and data only change on a transfer. They hold their last
  //   values otherwise.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_en   <= 4'b0000;
      wr_addr <= '0;
      wr_data <= '0;
    end else begin
      wr_en <= transfer ? (4'b0001 << idx[1:0]) : 4'b0000;
      if (transfer) begin
        wr_addr <= idx[IDX_W-1:2];
        wr_data <= reduced;
      end
    end
  end

  // Out-of-range flag. It is set by any accepted coefficient >= 2Q and stays
  // set for the rest of the load. It clears only when the next load begins,
  // so software can read it after the transform has finished.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      range_err <= 1'b0;
    end else if (load_start) begin
      range_err <= 1'b0;
    end else if (transfer && over_2q) begin
      range_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_bank_loader.sv
// ---------------------------------------------------------------------------
// tb_bank_loader
//
// Self-checking bench for bank_loader.
// - Every accepted coefficient pushes its expected bank write (one-hot
//   enable, address, reduced data, sticky error flag) onto a queue.
// - A monitor pops and compares one entry per cycle once the registered
//   write should be visible.
// - A table of range-check vectors and hand-written sequences cover the
//   flush, launch, WAIT_NTT and reset corner cases.
// ---------------------------------------------------------------------------
module tb_bank_loader;

  localparam int DATA_W = 13;
  localparam int Q      = 3329;
  localparam int N      = 256;
  localparam int ADDR_W = 6;

  logic              clk;
  logic              rst;
  logic              load_req;
  logic              in_valid;
  logic [DATA_W-1:0] in_data;
  logic              in_ready;
  logic [3:0]        wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              start_ntt;
  logic              ntt_done;
  logic              busy;
  logic              range_err;

  bank_loader #(
    .DATA_W(DATA_W),
    .Q     (Q),
    .N     (N),
    .ADDR_W(ADDR_W)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .load_req (load_req),
    .in_valid (in_valid),
    .in_data  (in_data),
    .in_ready (in_ready),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .start_ntt(start_ntt),
    .ntt_done (ntt_done),
    .busy     (busy),
    .range_err(range_err)
  );

  typedef struct {
    logic [3:0]        bank_oh;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
    logic              err;
  } wr_t;

  typedef struct {
    int   data;
    int   exp_data;
    logic exp_err;
  } vec_t;

  wr_t  exp_q[$];
  wr_t  mon_w;
  vec_t table_v[5];

  int   compared    = 0;
  int   mismatched  = 0;
  int   exp_idx     = 0;
  logic exp_err     = 1'b0;
  int   start_count = 0;
  int   start_before;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single reduction by Q, written independently of the design.
  function automatic logic [DATA_W-1:0] model_reduce(input int d);
    if (d >= Q) return DATA_W'(d - Q);
    return DATA_W'(d);
  endfunction

  task automatic checkOutput(input string name, input int actual, input int expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  // Drives one cycle of input on the falling edge. If the DUT is ready and
  // the beat is valid, the expected write is queued for the monitor.
  task automatic applyStimulus(input logic valid, input int data);
    wr_t w;
    @(negedge clk);
    in_valid = valid;
    in_data  = DATA_W'(data);
    if (valid && in_ready) begin
      if (data >= 2 * Q) exp_err = 1'b1;
      w.bank_oh = 4'(1 << (exp_idx % 4));
      w.addr    = ADDR_W'(exp_idx / 4);
      w.data    = model_reduce(data);
      w.err     = exp_err;
      exp_q.push_back(w);
      exp_idx++;
    end
  endtask

  // Pulses load_req for one cycle and checks that the load was entered.
  task automatic startLoad();
    @(negedge clk);
    load_req = 1'b1;
    @(posedge clk);
    #1;
    load_req = 1'b0;
    exp_idx  = 0;
    exp_err  = 1'b0;
    checkOutput("load entry busy", int'(busy), 1);
    checkOutput("load entry in_ready", int'(in_ready), 1);
    checkOutput("load entry range_err", int'(range_err), 0);
  endtask

  // Follows the last transfer through FLUSH, START and WAIT_NTT.
  // If done_early is set, ntt_done is already high and WAIT_NTT must last one
  // cycle. Otherwise the task checks that a load_req inside WAIT_NTT is
  // ignored, then raises ntt_done.
  task automatic checkFinish(input logic done_early);
    start_before = start_count;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    checkOutput("flush wr_en", int'(wr_en), 8);
    checkOutput("flush wr_addr", int'(wr_addr), N / 4 - 1);
    checkOutput("flush start_ntt", int'(start_ntt), 0);
    checkOutput("flush in_ready", int'(in_ready), 0);
    checkOutput("flush busy", int'(busy), 1);
    @(posedge clk);
    #1;
    checkOutput("start pulse", int'(start_ntt), 1);
    checkOutput("start wr_en", int'(wr_en), 0);
    @(posedge clk);
    #1;
    checkOutput("wait start_ntt low", int'(start_ntt), 0);
    checkOutput("wait busy", int'(busy), 1);
    if (done_early) begin
      @(posedge clk);
      #1;
      checkOutput("early done idle", int'(busy), 0);
    end else begin
      @(negedge clk);
      load_req = 1'b1;
      @(posedge clk);
      #1;
      load_req = 1'b0;
      checkOutput("wait ignores load_req busy", int'(busy), 1);
      checkOutput("wait ignores load_req ready", int'(in_ready), 0);
      @(posedge clk);
      #1;
      checkOutput("wait holds wr_en", int'(wr_en), 0);
      @(negedge clk);
      ntt_done = 1'b1;
      @(posedge clk);
      #1;
      checkOutput("done idle busy", int'(busy), 0);
      @(negedge clk);
      ntt_done = 1'b0;
    end
    repeat (3) @(posedge clk);
    #1;
    checkOutput("single start pulse", start_count - start_before, 1);
    checkOutput("idle stays idle", int'(busy), 0);
  endtask

  // Monitor. One posedge after a transfer the registered write must be
  // visible. A write with nothing expected is reported as spurious.
  always begin
    @(posedge clk);
    #1;
    if (start_ntt) start_count++;
    if (exp_q.size() > 0) begin
      mon_w = exp_q.pop_front();
      checkOutput("wr_en", int'(wr_en), int'(mon_w.bank_oh));
      checkOutput("wr_addr", int'(wr_addr), int'(mon_w.addr));
      checkOutput("wr_data", int'(wr_data), int'(mon_w.data));
      checkOutput("range_err", int'(range_err), int'(mon_w.err));
    end else if (wr_en != 4'b0000) begin
      checkOutput("spurious wr_en", int'(wr_en), 0);
    end
  end

  // Stops a runaway simulation with a visible failure.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    table_v[0] = '{3328, 3328, 1'b0};
    table_v[1] = '{3329, 0,    1'b0};
    table_v[2] = '{3330, 1,    1'b0};
    table_v[3] = '{6658, 3329, 1'b1};
    table_v[4] = '{100,  100,  1'b1};

    rst      = 1'b1;
    load_req = 1'b0;
    in_valid = 1'b0;
    in_data  = '0;
    ntt_done = 1'b0;

    // Reset state.
    repeat (2) @(negedge clk);
    checkOutput("reset in_ready", int'(in_ready), 0);
    checkOutput("reset busy", int'(busy), 0);
    checkOutput("reset wr_en", int'(wr_en), 0);
    checkOutput("reset wr_addr", int'(wr_addr), 0);
    checkOutput("reset wr_data", int'(wr_data), 0);
    checkOutput("reset start_ntt", int'(start_ntt), 0);
    checkOutput("reset range_err", int'(range_err), 0);

    // The first load_req is honoured on the first edge after reset release.
    @(negedge clk);
    rst      = 1'b0;
    load_req = 1'b1;
    @(posedge clk);
    #1;
    load_req = 1'b0;
    exp_idx  = 0;
    exp_err  = 1'b0;
    checkOutput("first load busy", int'(busy), 1);
    checkOutput("first load in_ready", int'(in_ready), 1);

    // Load 1: ramp 0..N-1 with in_valid held high.
    for (int i = 0; i < N; i++) applyStimulus(1'b1, i);
    checkFinish(1'b0);
    checkOutput("load1 range_err", int'(range_err), 0);

    // Load 2: range vectors with a 1-on/2-off valid pattern. ntt_done is held
    // high throughout.
    startLoad();
    ntt_done = 1'b1;
    for (int k = 0; k < 5; k++) begin
      applyStimulus(1'b1, table_v[k].data);
      @(posedge clk);
      #1;
      checkOutput("table wr_data", int'(wr_data), table_v[k].exp_data);
      checkOutput("table range_err", int'(range_err), int'(table_v[k].exp_err));
      checkOutput("table wr_en", int'(wr_en), 1 << (k % 4));
      applyStimulus(1'b0, 0);
      applyStimulus(1'b0, 0);
    end
    for (int i = 5; i < N; i++) begin
      applyStimulus(1'b1, i);
      if (i != N - 1) begin
        applyStimulus(1'b0, 0);
        applyStimulus(1'b0, 0);
      end
    end
    checkFinish(1'b1);
    ntt_done = 1'b0;
    checkOutput("load2 range_err sticky", int'(range_err), 1);

    // Load 3: reset after 100 transfers, then a fresh load from index 0.
    startLoad();
    for (int i = 0; i < 100; i++) applyStimulus(1'b1, 4000 - i);
    @(negedge clk);
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    @(negedge clk);
    rst = 1'b1;
    repeat (3) begin
      @(posedge clk);
      #1;
      checkOutput("mid reset wr_en", int'(wr_en), 0);
      checkOutput("mid reset busy", int'(busy), 0);
      checkOutput("mid reset in_ready", int'(in_ready), 0);
    end
    checkOutput("mid reset range_err", int'(range_err), 0);
    @(negedge clk);
    rst = 1'b0;
    start_before = start_count;
    repeat (4) begin
      @(posedge clk);
      #1;
      checkOutput("after reset wr_en", int'(wr_en), 0);
      checkOutput("after reset busy", int'(busy), 0);
    end
    checkOutput("after reset no start", start_count - start_before, 0);

    startLoad();
    applyStimulus(1'b1, 4000);
    @(posedge clk);
    #1;
    checkOutput("reload first wr_en", int'(wr_en), 1);
    checkOutput("reload first wr_addr", int'(wr_addr), 0);
    for (int i = 1; i < N; i++) applyStimulus(1'b1, 4000 - i);
    checkFinish(1'b0);

    repeat (2) @(posedge clk);
    #1;
    checkOutput("scoreboard drained", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
